// File: rtl/mxint_vector_serializer.sv
`default_nettype none
// ============================================================================
// Module      : mxint_vector_serializer
// Description : Captures a whole MXINT vector (DIM blocks, each holding
//               PARALLELISM mantissas and one shared exponent) on an input
//               handshake. It then streams the blocks out one at a time, in
//               ascending index order, using a valid/ready handshake.
//               A new vector can be accepted in the same cycle that the last
//               block leaves. This allows back-to-back vectors with no bubble.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               mdata_in_0/edata_in_0, data_in_0_valid/ready
//                                   - whole-vector input side
//               mdata_out_0/edata_out_0, data_out_0_valid/ready/last
//                                   - per-block output side
// Revision    : 1.0 - initial release
// ============================================================================
module mxint_vector_serializer #(
   parameter int DATA_IN_0_PRECISION_0 = 4,
   parameter int DATA_IN_0_PRECISION_1 = 8,
   parameter int DATA_IN_0_DIM         = 8,
   parameter int DATA_IN_0_PARALLELISM = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [DATA_IN_0_PRECISION_0-1:0] mdata_in_0 [DATA_IN_0_DIM*DATA_IN_0_PARALLELISM-1:0],
   input  logic [DATA_IN_0_PRECISION_1-1:0] edata_in_0 [DATA_IN_0_DIM-1:0],
   input  logic                             data_in_0_valid,
   output logic                             data_in_0_ready,
   output logic [DATA_IN_0_PRECISION_0-1:0] mdata_out_0 [DATA_IN_0_PARALLELISM-1:0],
   output logic [DATA_IN_0_PRECISION_1-1:0] edata_out_0,
   output logic                             data_out_0_valid,
   input  logic                             data_out_0_ready,
   output logic                             data_out_0_last
);

   localparam int C_NUM_MANT = DATA_IN_0_DIM * DATA_IN_0_PARALLELISM;
   localparam int C_IDX_W    = (DATA_IN_0_DIM > 1) ? $clog2(DATA_IN_0_DIM) : 1;
   localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(DATA_IN_0_DIM - 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t                             state_q, state_d;
   logic [C_IDX_W-1:0]                 index_q, index_d;
   logic [DATA_IN_0_PRECISION_0-1:0]   mant_q [C_NUM_MANT-1:0];
   logic [DATA_IN_0_PRECISION_0-1:0]   mant_d [C_NUM_MANT-1:0];
   logic [DATA_IN_0_PRECISION_1-1:0]   exp_q  [DATA_IN_0_DIM-1:0];
   logic [DATA_IN_0_PRECISION_1-1:0]   exp_d  [DATA_IN_0_DIM-1:0];

   logic w_sending;
   logic w_at_last;
   logic w_in_hs;
   logic w_out_hs;

   assign w_sending = (state_q == S_SEND);
   assign w_at_last = (index_q == C_LAST_IDX);
   assign w_out_hs  = w_sending && data_out_0_ready;

   // The buffer may be reloaded while the final block is being accepted.
   // That block has already been consumed downstream in the same cycle.
   assign data_in_0_ready  = !w_sending || (w_at_last && data_out_0_ready);
   assign w_in_hs          = data_in_0_valid && data_in_0_ready;

   assign data_out_0_valid = w_sending;
   assign data_out_0_last  = w_sending && w_at_last;

   // Next-state / next-buffer computation
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      mant_d  = mant_q;
      exp_d   = exp_q;
      if (w_in_hs) begin
         // A capture takes precedence. It also covers the case where the last
         // block is leaving in the same cycle.
         state_d = S_SEND;
         index_d = '0;
         mant_d  = mdata_in_0;
         exp_d   = edata_in_0;
      end else if (w_out_hs) begin
         if (w_at_last) begin
            state_d = S_IDLE;
            index_d = '0;
         end else begin
            index_d = index_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         index_q <= '0;
         for (int i = 0; i < C_NUM_MANT; i++) begin
            mant_q[i] <= '0;
         end
         for (int i = 0; i < DATA_IN_0_DIM; i++) begin
            exp_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         mant_q  <= mant_d;
         exp_q   <= exp_d;
      end
   end

   // Block select. The loop uses only constant array indices, so no wide
   // computed index is needed. Non-power-of-two DIM values can never match
   // an out-of-range block.
   always_comb begin
      edata_out_0 = '0;
      for (int p = 0; p < DATA_IN_0_PARALLELISM; p++) begin
         mdata_out_0[p] = '0;
      end
      for (int b = 0; b < DATA_IN_0_DIM; b++) begin
         if (index_q == C_IDX_W'(b)) begin
            edata_out_0 = exp_q[b];
            for (int p = 0; p < DATA_IN_0_PARALLELISM; p++) begin
               mdata_out_0[p] = mant_q[b*DATA_IN_0_PARALLELISM + p];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mxint_vector_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mxint_vector_serializer
// Description : Self-checking bench for mxint_vector_serializer. Instance A
//               (DIM=4, PAR=1) is checked against a block-queue reference
//               model. Instance B (DIM=1, PAR=2) is checked with directed
//               values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mxint_vector_serializer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- instance A : DIM=4, PAR=1 ----------------
   logic [3:0] a_mi [3:0];
   logic [7:0] a_ei [3:0];
   logic       a_iv, a_ir;
   logic [3:0] a_mo [0:0];
   logic [7:0] a_eo;
   logic       a_ov, a_or, a_ol;

   mxint_vector_serializer #(
      .DATA_IN_0_PRECISION_0(4), .DATA_IN_0_PRECISION_1(8),
      .DATA_IN_0_DIM(4), .DATA_IN_0_PARALLELISM(1)
   ) u_dut_a (
      .clk(clk), .rst(rst),
      .mdata_in_0(a_mi), .edata_in_0(a_ei),
      .data_in_0_valid(a_iv), .data_in_0_ready(a_ir),
      .mdata_out_0(a_mo), .edata_out_0(a_eo),
      .data_out_0_valid(a_ov), .data_out_0_ready(a_or),
      .data_out_0_last(a_ol)
   );

   // ---------------- instance B : DIM=1, PAR=2 ----------------
   logic [3:0] b_mi [1:0];
   logic [7:0] b_ei [0:0];
   logic       b_iv, b_ir;
   logic [3:0] b_mo [1:0];
   logic [7:0] b_eo;
   logic       b_ov, b_or, b_ol;

   mxint_vector_serializer #(
      .DATA_IN_0_PRECISION_0(4), .DATA_IN_0_PRECISION_1(8),
      .DATA_IN_0_DIM(1), .DATA_IN_0_PARALLELISM(2)
   ) u_dut_b (
      .clk(clk), .rst(rst),
      .mdata_in_0(b_mi), .edata_in_0(b_ei),
      .data_in_0_valid(b_iv), .data_in_0_ready(b_ir),
      .mdata_out_0(b_mo), .edata_out_0(b_eo),
      .data_out_0_valid(b_ov), .data_out_0_ready(b_or),
      .data_out_0_last(b_ol)
   );

   // Reference model: the blocks that are still owed downstream, in order.
   typedef struct packed {
      logic [3:0] m;
      logic [7:0] e;
      logic       last;
   } blk_t;
   blk_t q[$];

   int tests = 0;
   int fails = 0;
   int accepted;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle on instance A. Inputs must already be applied; this task
   // is entered just after a falling edge.
   task automatic cyc_a();
      bit exp_ir, out_hs, in_hs;
      #1;
      exp_ir = (q.size() == 0) || (q.size() == 1 && a_or);
      chk("a_valid", a_ov, q.size() > 0);
      chk("a_in_ready", a_ir, exp_ir);
      if (q.size() > 0) begin
         chk("a_mant", a_mo[0], q[0].m);
         chk("a_exp",  a_eo,    q[0].e);
         chk("a_last", a_ol,    q[0].last);
      end
      out_hs = (q.size() > 0) && a_or;
      in_hs  = a_iv && exp_ir;
      if (out_hs) void'(q.pop_front());
      if (in_hs) begin
         accepted++;
         for (int b = 0; b < 4; b++) q.push_back('{m: a_mi[b], e: a_ei[b], last: (b == 3)});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_a(input logic [3:0] m0, m1, m2, m3, input logic [7:0] e0);
      a_mi[0] = m0; a_mi[1] = m1; a_mi[2] = m2; a_mi[3] = m3;
      for (int b = 0; b < 4; b++) a_ei[b] = e0 + 8'(b);
   endtask

   task automatic rand_a();
      for (int b = 0; b < 4; b++) begin
         a_mi[b] = 4'($urandom);
         a_ei[b] = 8'($urandom);
      end
   endtask

   initial begin
      rst = 1'b1;
      a_iv = 1'b0; a_or = 1'b0; b_iv = 1'b0; b_or = 1'b0;
      set_a(4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
      b_mi[0] = '0; b_mi[1] = '0; b_ei[0] = '0;
      accepted = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      // Reset state
      chk("rst_a_valid", a_ov, 0);
      chk("rst_a_last", a_ol, 0);
      chk("rst_a_mant", a_mo[0], 0);
      chk("rst_a_exp", a_eo, 0);
      chk("rst_a_in_ready", a_ir, 1);
      chk("rst_b_valid", b_ov, 0);
      chk("rst_b_mant1", b_mo[1], 0);
      chk("rst_b_exp", b_eo, 0);

      // Basic vector, ready held high
      a_or = 1'b1;
      set_a(4'd1, 4'd2, 4'd3, 4'd4, 8'd10);
      a_iv = 1'b1;
      cyc_a();
      a_iv = 1'b0;
      repeat (5) cyc_a();

      // Backpressure: stall 3 cycles while block 1 is presented
      rand_a();
      a_iv = 1'b1;
      cyc_a();
      a_iv = 1'b0;
      cyc_a();
      a_or = 1'b0;
      repeat (3) cyc_a();
      a_or = 1'b1;
      repeat (4) cyc_a();

      // Back-to-back: second vector offered while block 3 is on the output
      set_a(4'd1, 4'd2, 4'd3, 4'd4, 8'd10);
      a_iv = 1'b1;
      cyc_a();
      a_iv = 1'b0;
      repeat (3) cyc_a();
      set_a(4'd5, 4'd6, 4'd7, 4'd8, 8'd20);
      a_iv = 1'b1;
      cyc_a();
      a_iv = 1'b0;
      repeat (5) cyc_a();

      // Reset while block 2 is presented
      rand_a();
      a_iv = 1'b1;
      cyc_a();
      a_iv = 1'b0;
      repeat (2) cyc_a();
      chk("pre_rst_mant", a_mo[0], q[0].m);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      #1;
      chk("mid_rst_valid", a_ov, 0);
      chk("mid_rst_mant", a_mo[0], 0);
      chk("mid_rst_exp", a_eo, 0);
      chk("mid_rst_in_ready", a_ir, 1);
      rand_a();
      a_iv = 1'b1;
      cyc_a();
      a_iv = 1'b0;
      repeat (5) cyc_a();

      // Random valid/ready until 1000 vectors have been accepted
      accepted = 0;
      for (int n = 0; n < 20000 && accepted < 1000; n++) begin
         a_iv = 1'($urandom);
         a_or = ($urandom_range(0, 9) < 7);
         rand_a();
         cyc_a();
      end
      chk("rand_accepted", accepted, 1000);
      a_iv = 1'b0;
      a_or = 1'b1;
      for (int n = 0; n < 10 && q.size() > 0; n++) cyc_a();
      chk("rand_drained", q.size(), 0);

      // Instance B: DIM=1, PAR=2
      b_or = 1'b1;
      b_mi[0] = 4'd7; b_mi[1] = 4'hF; b_ei[0] = 8'd3;
      b_iv = 1'b1;
      #1;
      chk("b_ready_c0", b_ir, 1);
      chk("b_valid_c0", b_ov, 0);
      @(posedge clk);
      @(negedge clk);
      b_mi[0] = 4'd2; b_mi[1] = 4'd5; b_ei[0] = 8'd4;
      #1;
      chk("b_ready_c1", b_ir, 1);
      chk("b_valid_c1", b_ov, 1);
      chk("b_last_c1", b_ol, 1);
      chk("b_m0_c1", b_mo[0], 4'd7);
      chk("b_m1_c1", b_mo[1], 4'hF);
      chk("b_exp_c1", b_eo, 8'd3);
      @(posedge clk);
      @(negedge clk);
      b_iv = 1'b0;
      #1;
      chk("b_ready_c2", b_ir, 1);
      chk("b_valid_c2", b_ov, 1);
      chk("b_last_c2", b_ol, 1);
      chk("b_m0_c2", b_mo[0], 4'd2);
      chk("b_m1_c2", b_mo[1], 4'd5);
      chk("b_exp_c2", b_eo, 8'd4);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("b_valid_c3", b_ov, 0);
      chk("b_ready_c3", b_ir, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mxint_vector_serializer.md
MXINT_VECTOR_SERIALIZER -- requirements
Module: mxint_vector_serializer

Interface
REQ-001 SHALL have parameter DATA_IN_0_PRECISION_0, default 4, mantissa width in bits.
REQ-002 SHALL have parameter DATA_IN_0_PRECISION_1, default 8, shared-exponent width in bits.
REQ-003 SHALL have parameter DATA_IN_0_DIM, default 8, number of blocks per vector.
REQ-004 SHALL have parameter DATA_IN_0_PARALLELISM, default 1, mantissas per block.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port mdata_in_0, input, unpacked [DIM*PARALLELISM-1:0] of PRECISION_0, whole-vector mantissas; block b occupies indices b*PARALLELISM .. b*PARALLELISM+PARALLELISM-1.
REQ-008 SHALL have port edata_in_0, input, unpacked [DIM-1:0] of PRECISION_1, per-block shared exponents.
REQ-009 SHALL have port data_in_0_valid, input, 1, vector valid.
REQ-010 SHALL have port data_in_0_ready, output, 1, vector accepted when valid and ready are both high.
REQ-011 SHALL have port mdata_out_0, output, unpacked [PARALLELISM-1:0] of PRECISION_0, current block mantissas.
REQ-012 SHALL have port edata_out_0, output, PRECISION_1, current block exponent.
REQ-013 SHALL have port data_out_0_valid, output, 1, block valid.
REQ-014 SHALL have port data_out_0_ready, input, 1, downstream (e.g. mxint_softmax input) ready.
REQ-015 SHALL have port data_out_0_last, output, 1, high with the block whose index is DIM-1.

Function
REQ-016 SHALL capture the whole vector (mantissas and exponents) into an internal buffer on an input handshake.
REQ-017 SHALL implement states IDLE and SEND; IDLE->SEND on input handshake; SEND->IDLE on output handshake of block DIM-1 when no input handshake occurs in the same cycle; SEND->SEND (new vector, index 0) when both occur in the same cycle.
REQ-018 SHALL keep a block index counter of width max(1,$clog2(DIM)), reset to 0 on each capture, incremented on each output handshake, never exceeding DIM-1.
REQ-019 SHALL drive data_in_0_ready = (state==IDLE) OR (state==SEND AND index==DIM-1 AND data_out_0_ready).
REQ-020 SHALL assert data_out_0_valid exactly while in SEND; first block valid the cycle after capture (latency 1).
REQ-021 SHALL drive mdata_out_0/edata_out_0 from buffer block [index], unmodified bit-for-bit (no exponent alignment or rounding).
REQ-022 SHALL hold all outputs stable while data_out_0_valid high and data_out_0_ready low.
REQ-023 SHALL ignore data_in_0_* whenever data_in_0_ready is low; buffer unchanged.
REQ-024 SHALL emit blocks in ascending index order 0..DIM-1, each exactly once per accepted vector.
REQ-025 SHALL sustain one block per cycle with data_out_0_ready held high, including back-to-back vectors with no bubble.
REQ-026 SHALL, with DIM==1, assert data_out_0_last on every valid block and accept a new vector every cycle under continuous ready.

Reset
REQ-027 SHALL on rst: state IDLE, index 0, data_out_0_valid 0, data_out_0_last 0, buffer cleared so mdata_out_0 and edata_out_0 read 0.
REQ-028 SHALL on rst mid-vector discard remaining blocks; data_in_0_ready high the first cycle after rst deasserts.
REQ-029 SHALL give rst priority over any simultaneous handshake.

Verification
REQ-030 DIM=4,PAR=1: vector mant {1,2,3,4}, exp {10,11,12,13}, ready held high -> blocks (1,10),(2,11),(3,12),(4,13) on 4 consecutive cycles starting 1 cycle after capture; last only on (4,13).
REQ-031 Backpressure: ready low for 3 cycles during block 1 -> block 1 held stable, valid high, no block skipped or repeated.
REQ-032 Back-to-back: second vector {5,6,7,8} valid during block 3 -> captured same cycle block 3 accepted; block 0 of second vector next cycle, zero bubbles over 8 cycles.
REQ-033 Reset at block 2 -> valid 0 next cycle, outputs 0, next vector starts at block 0.
REQ-034 DIM=1,PAR=2: vectors {(7,-1),exp 3} then {(2,5),exp 4} with ready high -> one block per cycle, last always high, data_in_0_ready high every cycle.
REQ-035 Random stimulus, random valid/ready, 1000 vectors -> output block sequence matches scoreboard of concatenated input blocks exactly.
